// File: rtl/sequence_player.sv
// Plays pattern-memory entries 0..level-1 as timed one-hot LED flashes.
// Per entry: 2 fetch cycles, ON_CYCLES lit, GAP_CYCLES dark; done held until start drops.
module sequence_player #(
   parameter int ON_CYCLES  = 12_500_000,
   parameter int GAP_CYCLES = 6_250_000,
   parameter int MAX_LEVEL  = 10,
   parameter int CNT_W      = $clog2(((ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES) + 1)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] level,
   output logic       mem_rd_en,
   output logic [3:0] mem_addr,
   input  logic [1:0] mem_rd_data,
   output logic [3:0] led,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_ON,
      S_GAP,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic [3:0]       lvl_q, lvl_d;
   logic [1:0]       colour_q, colour_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       lvl_clamped;

   assign lvl_clamped = (level > 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : level;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         idx_q    <= 4'd0;
         lvl_q    <= 4'd0;
         colour_q <= 2'd0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         lvl_q    <= lvl_d;
         colour_q <= colour_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      lvl_d    = lvl_q;
      colour_d = colour_q;
      cnt_d    = cnt_q;
      // Dropping start aborts any in-flight playback; a pending read is simply never latched.
      if (!start && state_q != S_IDLE) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  lvl_d   = lvl_clamped;
                  idx_d   = 4'd0;
                  state_d = (lvl_clamped == 4'd0) ? S_DONE : S_FETCH;
               end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
               colour_d = mem_rd_data;
               cnt_d    = '0;
               state_d  = S_ON;
            end
            S_ON: begin
               if (cnt_q == CNT_W'(ON_CYCLES - 1)) begin
                  cnt_d   = '0;
                  state_d = S_GAP;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_GAP: begin
               if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                  cnt_d = '0;
                  if (idx_q == lvl_q - 4'd1) begin
                     state_d = S_DONE;
                  end else begin
                     idx_d   = idx_q + 4'd1;
                     state_d = S_FETCH;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign mem_rd_en = (state_q == S_FETCH);
   assign mem_addr  = (state_q == S_FETCH) ? idx_q : 4'd0;
   assign led       = (state_q == S_ON) ? (4'b0001 << colour_q) : 4'b0000;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_sequence_player.sv
// Bench for sequence_player: arithmetic playback-schedule model, per-cycle compare, directed + random stimulus.
module tb_sequence_player;

   localparam int ON  = 3;
   localparam int GAP = 2;
   localparam int P   = 2 + ON + GAP;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] level;
   logic       mem_rd_en;
   logic [3:0] mem_addr;
   logic [1:0] mem_rd_data = 2'd0;
   logic [3:0] led;
   logic       busy;
   logic       done;

   sequence_player #(.ON_CYCLES(ON), .GAP_CYCLES(GAP), .MAX_LEVEL(10)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .level      (level),
      .mem_rd_en  (mem_rd_en),
      .mem_addr   (mem_addr),
      .mem_rd_data(mem_rd_data),
      .led        (led),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Pattern memory: registered read, data valid the cycle after the strobe, garbage otherwise.
   logic [1:0] mem [16];
   logic       p_en = 1'b0;
   logic [3:0] p_addr = 4'd0;

   always @(negedge clk) begin
      p_en   = mem_rd_en;
      p_addr = mem_addr;
   end

   always @(posedge clk) begin
      #1;
      mem_rd_data = p_en ? mem[p_addr] : 2'($urandom);
   end

   // Model: playback is a schedule of entries P cycles long starting one cycle after the start edge.
   bit m_active = 0;
   int m_k = 0;
   int m_n = 0;

   always @(posedge clk) begin
      if (!reset)                     m_active = 0;
      else if (m_active && !start)    m_active = 0;
      else if (!m_active && start) begin
         m_active = 1;
         m_k      = 0;
         m_n      = (int'(level) > 10) ? 10 : int'(level);
      end else if (m_active)          m_k++;
   end

   bit cmp_en = 0;

   always @(negedge clk) begin
      int e_rd, e_addr, e_led, e_busy, e_done, j, off;
      if (cmp_en) begin
         e_rd = 0; e_addr = 0; e_led = 0; e_busy = 0; e_done = 0;
         if (m_active) begin
            e_busy = 1;
            if (m_k >= m_n * P) begin
               e_done = 1;
            end else begin
               j   = m_k / P;
               off = m_k % P;
               if (off == 0) begin
                  e_rd   = 1;
                  e_addr = j;
               end
               if (off >= 2 && off < 2 + ON) e_led = 1 << mem[j];
            end
         end
         check("mem_rd_en", int'(mem_rd_en), e_rd);
         if (e_rd == 1) check("mem_addr", int'(mem_addr), e_addr);
         check("led", int'(led), e_led);
         check("busy", int'(busy), e_busy);
         check("done", int'(done), e_done);
      end
   end

   initial begin
      int strobes, done_at;
      reset = 1'b0;
      start = 1'b0;
      level = 4'd0;
      mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3; mem[3] = 2'd1;
      for (int i = 4; i < 16; i++) mem[i] = 2'($urandom);

      repeat (3) @(negedge clk);
      check("rst_rd_en", int'(mem_rd_en), 0);
      check("rst_addr", int'(mem_addr), 0);
      check("rst_led", int'(led), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      reset  = 1'b1;
      cmp_en = 1;
      @(negedge clk);

      // level=2, start held well past done
      level = 4'd2; start = 1'b1;
      strobes = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1)  begin check("t1_rd1", int'(mem_rd_en), 1); check("t1_addr0", int'(mem_addr), 0); end
         if (c == 2)  check("t1_rd_off", int'(mem_rd_en), 0);
         if (c == 4)  check("t1_led_a", int'(led), 4);
         if (c == 6)  check("t1_gap", int'(led), 0);
         if (c == 8)  begin check("t1_rd2", int'(mem_rd_en), 1); check("t1_addr1", int'(mem_addr), 1); end
         if (c == 11) check("t1_led_b", int'(led), 1);
         if (c == 14) check("t1_notdone", int'(done), 0);
         if (c == 15) check("t1_done", int'(done), 1);
         if (c >= 15 && mem_rd_en) strobes++;
      end
      check("t1_done_held", int'(done), 1);
      check("t1_no_replay", strobes, 0);
      start = 1'b0;
      @(negedge clk);
      check("t1_idle_busy", int'(busy), 0);
      start = 1'b1;
      @(negedge clk);
      check("rearm_rd", int'(mem_rd_en), 1);
      check("rearm_addr", int'(mem_addr), 0);
      start = 1'b0;
      @(negedge clk);

      // level=0 goes straight to done
      level = 4'd0; start = 1'b1;
      @(negedge clk);
      check("l0_done", int'(done), 1);
      check("l0_rd", int'(mem_rd_en), 0);
      start = 1'b0;
      @(negedge clk);

      // level=13 clamps to 10; mid-play level change ignored
      level = 4'd13; start = 1'b1;
      strobes = 0; done_at = -1;
      for (int c = 1; c <= 75; c++) begin
         @(negedge clk);
         if (c == 5) level = 4'd1;
         if (mem_rd_en) strobes++;
         if (done && done_at < 0) done_at = c;
      end
      check("l13_strobes", strobes, 10);
      check("l13_done_at", done_at, 71);
      start = 1'b0;
      @(negedge clk);

      // abort during ON, then replay from address 0
      level = 4'd3; start = 1'b1;
      repeat (4) @(negedge clk);
      check("abort_led_on", int'(led), 4);
      start = 1'b0;
      @(negedge clk);
      check("abort_led", int'(led), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      start = 1'b1;
      @(negedge clk);
      check("abort_replay_addr", int'(mem_addr), 0);
      check("abort_replay_rd", int'(mem_rd_en), 1);
      start = 1'b0;
      @(negedge clk);

      // reset mid-playback
      level = 4'd2; start = 1'b1;
      repeat (9) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("mrst_led", int'(led), 0);
      check("mrst_busy", int'(busy), 0);
      check("mrst_rd", int'(mem_rd_en), 0);
      reset = 1'b1; start = 1'b0;
      @(negedge clk);

      // random traffic: aborts, resets, level churn
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (start) begin
            if ($urandom_range(0, 59) == 0) start = 1'b0;
         end else begin
            if ($urandom_range(0, 4) == 0) start = 1'b1;
         end
         if ($urandom_range(0, 3) == 0) level = 4'($urandom);
         reset = ($urandom_range(0, 299) != 0);
      end
      reset = 1'b1; start = 1'b0;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
